// File: rtl/ksa_pkg.sv
// Shared types and constants for the RC4 key-scheduling stage.
// No logic; no latency; no flow control.
// Imported by the interface, key selector and ksa_shuffle top.
package ksa_pkg;

    localparam int S_SIZE            = 256;
    localparam int KEY_BYTES_DEFAULT = 3;

    typedef enum logic [2:0] {
        IDLE,
        READ_I,
        WAIT_I,
        READ_J,
        WAIT_J,
        WRITE_I,
        WRITE_J,
        DONE
    } state_t;

endpackage

// File: rtl/ksa_shuffle_if.sv
// Single-port S-memory bus between the key scheduler (master) and the shared 256x8 RAM (slave).
// Synchronous read: q is valid one cycle after address.
// No backpressure; the master owns every cycle of the port.
interface ksa_shuffle_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] q;
    logic              write;

    modport master (output address, output data, output write, input q);
    modport slave  (input address, input data, input write, output q);
endinterface

// File: rtl/ksa_key_select.sv
// Picks key byte k out of the packed key; byte 0 is the most significant byte.
// Combinational, zero latency.
// No flow control.
module ksa_key_select #(
    parameter int KEY_BYTES = 3,
    parameter int K_W       = 2
) (
    input  logic [8*KEY_BYTES-1:0] key,
    input  logic [K_W-1:0]         k,
    output logic [7:0]             keybyte
);

    always_comb begin
        keybyte = '0;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (k == K_W'(b)) begin
                keybyte = key[8*(KEY_BYTES-1-b) +: 8];
            end
        end
    end

endmodule

// File: rtl/ksa_shuffle.sv
// RC4 key scheduling over the shared S-memory; optional KSA_SAME_INDEX_SKIP_EN skips i==j swaps.
// Latency: 1 + 256*6 cycles from start to done (2-cycle iterations when i==j is skipped).
// No backpressure: start is a level request, done is held until start drops.
module ksa_shuffle
    import ksa_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int KEY_BYTES = KEY_BYTES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic                   done,
    ksa_shuffle_if.master          mem
);

    localparam int K_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    state_t                 state;
    logic [ADDR_W-1:0]      i;
    logic [ADDR_W-1:0]      j;
    logic [ADDR_W-1:0]      j_next;
    logic [K_W-1:0]         k;
    logic [K_W-1:0]         k_next;
    logic [DATA_W-1:0]      si;
    logic [8*KEY_BYTES-1:0] key_r;
    logic [7:0]             keybyte;
    logic                   i_last;

    ksa_key_select #(
        .KEY_BYTES (KEY_BYTES),
        .K_W       (K_W)
    ) u_key_select (
        .key     (key_r),
        .k       (k),
        .keybyte (keybyte)
    );

    always_comb begin
        j_next = j + ADDR_W'(mem.q) + ADDR_W'(keybyte);
        k_next = (k == K_W'(KEY_BYTES - 1)) ? '0 : k + K_W'(1);
        i_last = (i == {ADDR_W{1'b1}});
    end

    // Memory-facing outputs are registered on the transition into the state that owns them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            i           <= '0;
            j           <= '0;
            k           <= '0;
            si          <= '0;
            key_r       <= '0;
            done        <= 1'b0;
            mem.write   <= 1'b0;
            mem.address <= '0;
            mem.data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        key_r       <= key;
                        mem.address <= i;
                        state       <= READ_I;
                    end
                end
                READ_I: state <= WAIT_I;
                WAIT_I: begin
                    si <= mem.q;
                    j  <= j_next;
`ifdef KSA_SAME_INDEX_SKIP_EN
                    if (j_next == i) begin
                        // Swapping an entry with itself is a no-op; go straight to the next i.
                        i <= i + ADDR_W'(1);
                        k <= k_next;
                        if (i_last) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            mem.address <= i + ADDR_W'(1);
                            state       <= READ_I;
                        end
                    end else begin
                        mem.address <= j_next;
                        state       <= READ_J;
                    end
`else
                    mem.address <= j_next;
                    state       <= READ_J;
`endif
                end
                READ_J: state <= WAIT_J;
                WAIT_J: begin
                    mem.address <= i;
                    mem.data    <= mem.q;
                    mem.write   <= 1'b1;
                    state       <= WRITE_I;
                end
                WRITE_I: begin
                    mem.address <= j;
                    mem.data    <= si;
                    mem.write   <= 1'b1;
                    state       <= WRITE_J;
                end
                WRITE_J: begin
                    mem.write <= 1'b0;
                    i         <= i + ADDR_W'(1);
                    k         <= k_next;
                    if (i_last) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        mem.address <= i + ADDR_W'(1);
                        state       <= READ_I;
                    end
                end
                DONE: begin
                    if (!start) begin
                        done  <= 1'b0;
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
